// File: rtl/excp_ctrl_if.sv
// WB/CSR/IF bundle for the exception and ERTN sequencer.
// The sequencer uses the slave modport; the pipeline side (or a bench) uses master.
interface excp_ctrl_if;
    logic        ws_valid;
    logic [31:0] ws_pc;
    logic [31:0] ws_vaddr;
    logic [5:0]  ws_excp;
    logic        ws_ertn;
    logic        ws_csr_we;
    logic [13:0] ws_csr_num;
    logic [31:0] ws_csr_wmask;
    logic [31:0] ws_csr_wvalue;
    logic        has_int;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        redir_ready;

    logic        ws_allowin;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc;
    logic [31:0] wb_vaddr;
    logic        eret_flush;
    logic        csr_we;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        flush;
    logic        redir_valid;
    logic [31:0] redir_pc;

    modport slave (
        input  ws_valid, ws_pc, ws_vaddr, ws_excp, ws_ertn,
        input  ws_csr_we, ws_csr_num, ws_csr_wmask, ws_csr_wvalue,
        input  has_int, csr_eentry, csr_era, redir_ready,
        output ws_allowin, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
        output eret_flush, csr_we, csr_num, csr_wmask, csr_wvalue,
        output flush, redir_valid, redir_pc
    );

    modport master (
        output ws_valid, ws_pc, ws_vaddr, ws_excp, ws_ertn,
        output ws_csr_we, ws_csr_num, ws_csr_wmask, ws_csr_wvalue,
        output has_int, csr_eentry, csr_era, redir_ready,
        input  ws_allowin, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr,
        input  eret_flush, csr_we, csr_num, csr_wmask, csr_wvalue,
        input  flush, redir_valid, redir_pc
    );
endinterface

// File: rtl/excp_ctrl.sv
// Exception/ERTN sequencer: ranks WB exceptions, drives CSR commit strobes,
// then runs a flush + fetch-redirect handshake with IF while stalling WB.
module excp_ctrl (
    input  logic        clk,
    input  logic        resetn,
    excp_ctrl_if.slave  bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REDIR = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] redir_pc_q, redir_pc_d;

    logic        in_idle;
    logic        ex_src;
    logic        ex_req;
    logic        ert_req;
    logic        event_req;
    logic [5:0]  ecode;
    logic        unused_rsvd;

    assign unused_rsvd = bus.ws_excp[0];

    // has_int and the WB flags only count while IDLE holds a valid instruction.
    always_comb begin
        in_idle   = (state_q == IDLE);
        ex_src    = bus.has_int | (|bus.ws_excp[5:1]);
        ex_req    = in_idle & bus.ws_valid & ex_src;
        ert_req   = in_idle & bus.ws_valid & bus.ws_ertn & ~ex_src;
        event_req = ex_req | ert_req;
    end

    always_comb begin
        ecode = 6'h00;
        if (bus.has_int)         ecode = 6'h00;
        else if (bus.ws_excp[1]) ecode = 6'h08;
        else if (bus.ws_excp[2]) ecode = 6'h0B;
        else if (bus.ws_excp[3]) ecode = 6'h0C;
        else if (bus.ws_excp[4]) ecode = 6'h0D;
        else if (bus.ws_excp[5]) ecode = 6'h09;
    end

    // ERA is captured here, before the CSR file applies the ERTN update.
    always_comb begin
        state_d    = state_q;
        redir_pc_d = redir_pc_q;
        case (state_q)
            IDLE: begin
                if (event_req) begin
                    state_d    = REDIR;
                    redir_pc_d = ex_req ? bus.csr_eentry : bus.csr_era;
                end
            end
            REDIR: begin
                if (bus.redir_ready) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            redir_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign bus.ws_allowin  = in_idle;
    assign bus.wb_ex       = ex_req;
    assign bus.wb_ecode    = ex_req ? ecode : 6'h00;
    assign bus.wb_esubcode = 9'h000;
    assign bus.wb_pc       = bus.ws_pc;
    assign bus.wb_vaddr    = bus.ws_vaddr;
    assign bus.eret_flush  = ert_req;

    // A csrwr from a faulting instruction must never reach the CSR file.
    assign bus.csr_we      = in_idle & bus.ws_valid & bus.ws_csr_we & ~ex_src;
    assign bus.csr_num     = bus.ws_csr_num;
    assign bus.csr_wmask   = bus.ws_csr_wmask;
    assign bus.csr_wvalue  = bus.ws_csr_wvalue;

    assign bus.flush       = event_req | ~in_idle;
    assign bus.redir_valid = (state_q == REDIR);
    assign bus.redir_pc    = (state_q == REDIR) ? redir_pc_q : 32'h0;

endmodule

// File: tb/tb_excp_ctrl.sv
// Scoreboard bench for excp_ctrl: stimulus pushes per-cycle expectations from a
// behavioural model, an independent negedge monitor pops and compares them.
module tb_excp_ctrl;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    excp_ctrl_if bus ();

    excp_ctrl dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        allowin;
        logic        wb_ex;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] wb_pc;
        logic [31:0] wb_vaddr;
        logic        eret;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wval;
        logic        flush;
        logic        rvalid;
        logic [31:0] rpc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: an outstanding redirect (target awaiting acceptance) and a drain count.
    bit          m_pending = 1'b0;
    logic [31:0] m_target  = 32'h0;
    int          m_drain   = 0;
    int          code_of_bit[6] = '{0, 8, 11, 12, 13, 9};

    task automatic apply_stimulus(
        input logic        rst_low,
        input logic        v,
        input logic [31:0] pc,
        input logic [31:0] vaddr,
        input logic [5:0]  excp,
        input logic        ertn,
        input logic        cwe,
        input logic [13:0] num,
        input logic [31:0] mask,
        input logic [31:0] wval,
        input logic        hint,
        input logic [31:0] eentry,
        input logic [31:0] era,
        input logic        ready
    );
        exp_t e;
        bit   free, any_ex, ex, ert, found;
        int   code;
        @(posedge clk);
        #1;
        resetn            = ~rst_low;
        bus.ws_valid      = v;
        bus.ws_pc         = pc;
        bus.ws_vaddr      = vaddr;
        bus.ws_excp       = excp;
        bus.ws_ertn       = ertn;
        bus.ws_csr_we     = cwe;
        bus.ws_csr_num    = num;
        bus.ws_csr_wmask  = mask;
        bus.ws_csr_wvalue = wval;
        bus.has_int       = hint;
        bus.csr_eentry    = eentry;
        bus.csr_era       = era;
        bus.redir_ready   = ready;
        if (rst_low) begin
            m_pending = 1'b0;
            m_target  = 32'h0;
            m_drain   = 0;
        end
        free   = !m_pending && (m_drain == 0);
        any_ex = hint || (excp[5:1] != 5'b0);
        ex     = free && v && any_ex;
        ert    = free && v && ertn && !any_ex;
        code   = 0;
        found  = 1'b0;
        if (!hint) begin
            for (int b = 1; b <= 5; b++) begin
                if (excp[b] && !found) begin
                    code  = code_of_bit[b];
                    found = 1'b1;
                end
            end
        end
        e.allowin  = free;
        e.wb_ex    = ex;
        e.ecode    = ex ? 6'(code) : 6'h00;
        e.esub     = 9'h0;
        e.wb_pc    = pc;
        e.wb_vaddr = vaddr;
        e.eret     = ert;
        e.csr_we   = free && v && cwe && !any_ex;
        e.csr_num  = num;
        e.wmask    = mask;
        e.wval     = wval;
        e.flush    = ex || ert || !free;
        e.rvalid   = m_pending;
        e.rpc      = m_pending ? m_target : 32'h0;
        exp_q.push_back(e);
        if (!rst_low) begin
            if (m_pending) begin
                if (ready) begin
                    m_pending = 1'b0;
                    m_drain   = 1;
                end
            end else if (m_drain > 0) begin
                m_drain = m_drain - 1;
            end else if (ex || ert) begin
                m_pending = 1'b1;
                m_target  = ex ? eentry : era;
            end
        end
    endtask

    task automatic idle_cycles(input int n, input logic ready);
        for (int i = 0; i < n; i++)
            apply_stimulus(1'b0, 1'b0, $urandom, $urandom, 6'h0, 1'b0, 1'b0, 14'h0,
                           32'h0, 32'h0, 1'b0, $urandom, $urandom, ready);
    endtask

    task automatic check_field(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    task automatic check_output(input exp_t e);
        check_field("ws_allowin",  32'(bus.ws_allowin),  32'(e.allowin));
        check_field("wb_ex",       32'(bus.wb_ex),       32'(e.wb_ex));
        check_field("wb_ecode",    32'(bus.wb_ecode),    32'(e.ecode));
        check_field("wb_esubcode", 32'(bus.wb_esubcode), 32'(e.esub));
        check_field("wb_pc",       bus.wb_pc,            e.wb_pc);
        check_field("wb_vaddr",    bus.wb_vaddr,         e.wb_vaddr);
        check_field("eret_flush",  32'(bus.eret_flush),  32'(e.eret));
        check_field("csr_we",      32'(bus.csr_we),      32'(e.csr_we));
        check_field("csr_num",     32'(bus.csr_num),     32'(e.csr_num));
        check_field("csr_wmask",   bus.csr_wmask,        e.wmask);
        check_field("csr_wvalue",  bus.csr_wvalue,       e.wval);
        check_field("flush",       32'(bus.flush),       32'(e.flush));
        check_field("redir_valid", 32'(bus.redir_valid), 32'(e.rvalid));
        check_field("redir_pc",    bus.redir_pc,         e.rpc);
    endtask

    // Monitor: runs independently of the stimulus, one expectation per cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin
        resetn            = 1'b0;
        bus.ws_valid      = 1'b0;
        bus.ws_pc         = 32'h0;
        bus.ws_vaddr      = 32'h0;
        bus.ws_excp       = 6'h0;
        bus.ws_ertn       = 1'b0;
        bus.ws_csr_we     = 1'b0;
        bus.ws_csr_num    = 14'h0;
        bus.ws_csr_wmask  = 32'h0;
        bus.ws_csr_wvalue = 32'h0;
        bus.has_int       = 1'b0;
        bus.csr_eentry    = 32'h0;
        bus.csr_era       = 32'h0;
        bus.redir_ready   = 1'b0;

        // Reset state with all inputs quiet.
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0,
                       1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycles(2, 1'b0);

        // SYS with immediate acceptance.
        apply_stimulus(1'b0, 1'b1, 32'h1C000010, 32'h0, 6'b000100, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0,
                       1'b0, 32'h1C008000, 32'h0, 1'b1);
        idle_cycles(4, 1'b1);

        // ERTN with IF stalling for three cycles.
        apply_stimulus(1'b0, 1'b1, 32'h1C000200, 32'h0, 6'h0, 1'b1, 1'b0, 14'h0, 32'h0, 32'h0,
                       1'b0, 32'h0, 32'h1C000104, 1'b0);
        idle_cycles(3, 1'b0);
        idle_cycles(4, 1'b1);

        // Interrupt beats ALE, ERTN and csrwr.
        apply_stimulus(1'b0, 1'b1, 32'h1C000300, 32'h44, 6'b100000, 1'b1, 1'b1, 14'h30,
                       32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'h1C00_8800, 32'h1C00_0400, 1'b1);
        idle_cycles(4, 1'b1);

        // ADEF|INE, then a second valid event while the redirect is pending.
        apply_stimulus(1'b0, 1'b1, 32'h1C000404, 32'h0000DEAD, 6'b010010, 1'b0, 1'b0, 14'h0,
                       32'h0, 32'h0, 1'b0, 32'h1C00_9000, 32'h0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h1C000408, 32'h0, 6'b000100, 1'b0, 1'b0, 14'h0,
                       32'h0, 32'h0, 1'b1, 32'h1C00_A000, 32'h0, 1'b0);
        idle_cycles(4, 1'b1);

        // Plain csrwr.
        apply_stimulus(1'b0, 1'b1, 32'h1C000500, 32'h0, 6'h0, 1'b0, 1'b1, 14'h30,
                       32'h0000_FFFF, 32'hCAFE_BABE, 1'b0, 32'h0, 32'h0, 1'b1);
        idle_cycles(2, 1'b1);

        // Reset while a redirect is outstanding, then a normal SYS.
        apply_stimulus(1'b0, 1'b1, 32'h1C000600, 32'h0, 6'b000100, 1'b0, 1'b0, 14'h0,
                       32'h0, 32'h0, 1'b0, 32'h1C00_B000, 32'h0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 14'h0, 32'h0, 32'h0,
                       1'b0, 32'h0, 32'h0, 1'b0);
        idle_cycles(1, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h1C000700, 32'h0, 6'b000100, 1'b0, 1'b0, 14'h0,
                       32'h0, 32'h0, 1'b0, 32'h1C00_C000, 32'h0, 1'b1);
        idle_cycles(4, 1'b1);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(1'b0,
                           1'($urandom_range(0, 3) != 0),
                           $urandom, $urandom,
                           ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0,
                           1'($urandom_range(0, 4) == 0),
                           1'($urandom_range(0, 2) == 0),
                           14'($urandom), $urandom, $urandom,
                           1'($urandom_range(0, 6) == 0),
                           $urandom, $urandom,
                           1'($urandom_range(0, 4) != 0));
        end

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
